// File: rtl/alu_seq.sv
// alu_seq: single-request ALU with ready/valid handshakes on both sides.
// Single-cycle ops complete on the accept edge; MUL runs a shift-add
// multiplier for WIDTH edges. Results and flags are held until consumed.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a request, in_ready = 1
// BUSY   | MUL in progress, one shift-add step per edge
// DONE   | result/flags presented, out_valid = 1, waiting for out_ready
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic [1:0]         state;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [SHW-1:0]     cnt;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH:0]     shl_ext;
    logic [WIDTH:0]     shr_ext;
    logic [SHW-1:0]     amt;
    logic [2*WIDTH-1:0] acc_next;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    // Single-cycle datapath. The shift vectors carry one extra bit that
    // catches the last bit shifted out (bit WIDTH for SHL, bit 0 for SHR).
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        amt     = b[SHW-1:0];
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        shl_ext = {1'b0, a} << amt;
        shr_ext = {a, 1'b0} >> amt;
        case (op)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_SHL: begin
                alu_res = shl_ext[WIDTH-1:0];
                alu_c   = (amt != '0) && shl_ext[WIDTH];
            end
            OP_SHR: begin
                alu_res = shr_ext[WIDTH:1];
                alu_c   = (amt != '0) && shr_ext[0];
            end
            default: begin
                alu_res = '0;
                alu_c   = 1'b0;
                alu_v   = 1'b0;
            end
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier LSB is set.
    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
    end

    // Control FSM plus result/flag registers; zero and negative are
    // registered alongside the result so reset can clear them to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            result   <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            negative <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (op == OP_MUL) begin
                            mcand  <= {{WIDTH{1'b0}}, a};
                            mplier <= b;
                            acc    <= '0;
                            cnt    <= SHW'(WIDTH - 1);
                            state  <= S_BUSY;
                        end else begin
                            result   <= alu_res;
                            zero     <= (alu_res == '0);
                            negative <= alu_res[WIDTH-1];
                            carry    <= alu_c;
                            overflow <= alu_v;
                            state    <= S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0) begin
                        result   <= acc_next[WIDTH-1:0];
                        zero     <= (acc_next[WIDTH-1:0] == '0);
                        negative <= acc_next[WIDTH-1];
                        carry    <= |acc_next[2*WIDTH-1:WIDTH];
                        overflow <= 1'b0;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH = 8): directed vectors with literal expectations,
// randomized traffic checked against an arithmetic model, backpressure and
// reset-in-flight scenarios.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;
    logic [2:0] op = 3'd0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] result;
    logic       zero;
    logic       carry;
    logic       overflow;
    logic       negative;

    int errors = 0;
    int checks = 0;

    logic       exp_valid = 1'b0;
    logic [7:0] exp_r = 8'd0;
    logic       exp_c = 1'b0;
    logic       exp_v = 1'b0;
    logic       exp_z = 1'b0;
    logic       exp_n = 1'b0;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .carry(carry), .overflow(overflow),
        .negative(negative)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: returns {carry, overflow, result[7:0]} from plain arithmetic.
    function automatic logic [9:0] model(input logic [2:0] o, input int x, input int y);
        int r;
        int n;
        bit c;
        bit v;
        r = 0;
        c = 1'b0;
        v = 1'b0;
        n = y % 8;
        case (o)
            3'd0: begin
                r = (x + y) % 256;
                c = (x + y) > 255;
                v = ((x >= 128) == (y >= 128)) && ((r >= 128) != (x >= 128));
            end
            3'd1: begin
                r = (x - y + 256) % 256;
                c = x < y;
                v = ((x >= 128) != (y >= 128)) && ((r >= 128) != (x >= 128));
            end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: begin
                r = (x << n) % 256;
                c = (n != 0) ? (((x >> (8 - n)) & 1) == 1) : 1'b0;
            end
            3'd6: begin
                r = x >> n;
                c = (n != 0) ? (((x >> (n - 1)) & 1) == 1) : 1'b0;
            end
            default: begin
                r = (x * y) % 256;
                c = (x * y) > 255;
            end
        endcase
        return {c, v, 8'(r)};
    endfunction

    function automatic logic [7:0] pick_operand();
        case ($urandom % 8)
            0: return 8'h00;
            1: return 8'h01;
            2: return 8'h7F;
            3: return 8'h80;
            4: return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    // Checks result and flags whenever the DUT claims a valid output.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (exp_valid) begin
                chk("result",   32'(result),   32'(exp_r));
                chk("carry",    32'(carry),    32'(exp_c));
                chk("overflow", 32'(overflow), 32'(exp_v));
                chk("zero",     32'(zero),     32'(exp_z));
                chk("negative", 32'(negative), 32'(exp_n));
            end else begin
                chk("spurious_out_valid", 32'(out_valid), 32'd0);
            end
        end
    end

    // Issue one request (called at a negedge, returns at a negedge in IDLE).
    task automatic do_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] er, input logic ec, input logic ev,
                         input int hold, input string tag);
        int lat;
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        out_ready = 1'($urandom % 2);
        chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        exp_r = er;
        exp_c = ec;
        exp_v = ev;
        exp_z = (er == 8'd0);
        exp_n = er[7];
        exp_valid = 1'b1;
        lat = (o == 3'd7) ? 9 : 1;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k < lat) begin
                chk({tag, "_busy_out_valid"}, 32'(out_valid), 32'd0);
                chk({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
                in_valid = 1'($urandom % 2);
                a = 8'($urandom);
                b = 8'($urandom);
                op = 3'($urandom);
                out_ready = 1'($urandom % 2);
            end else begin
                chk({tag, "_latency_out_valid"}, 32'(out_valid), 32'd1);
                in_valid = 1'($urandom % 2);
                out_ready = (hold > 0) ? 1'b0 : 1'b1;
            end
        end
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            a = 8'($urandom);
            b = 8'($urandom);
            op = 3'($urandom);
            out_ready = 1'b0;
            @(negedge clk);
            chk({tag, "_hold_out_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_released_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_released_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_result"},    32'(result),    32'd0);
        chk({tag, "_zero"},      32'(zero),      32'd0);
        chk({tag, "_carry"},     32'(carry),     32'd0);
        chk({tag, "_overflow"},  32'(overflow),  32'd0);
        chk({tag, "_negative"},  32'(negative),  32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] m;
        logic [2:0] ro;
        logic [7:0] rx;
        logic [7:0] ry;

        repeat (2) @(negedge clk);
        chk_cleared("reset");

        // First accept on the first edge after release.
        rst_n = 1'b1;
        do_op(3'd0, 8'd10, 8'd5, 8'd15, 1'b0, 1'b0, 0, "first_add");

        // a=10, b=5 across ops 000..110.
        do_op(3'd1, 8'd10, 8'd5, 8'd5,   1'b0, 1'b0, 0, "sub_10_5");
        do_op(3'd2, 8'd10, 8'd5, 8'd0,   1'b0, 1'b0, 0, "and_10_5");
        do_op(3'd3, 8'd10, 8'd5, 8'd15,  1'b0, 1'b0, 0, "or_10_5");
        do_op(3'd4, 8'd10, 8'd5, 8'd15,  1'b0, 1'b0, 0, "xor_10_5");
        do_op(3'd5, 8'd10, 8'd5, 8'h40,  1'b1, 1'b0, 0, "shl_10_5");
        do_op(3'd6, 8'd10, 8'd5, 8'h00,  1'b0, 1'b0, 0, "shr_10_5");

        do_op(3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 0, "add_7f_01");
        do_op(3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 0, "add_ff_01");
        do_op(3'd1, 8'd5,  8'd10, 8'hFB, 1'b1, 1'b0, 0, "sub_5_10");
        do_op(3'd5, 8'h81, 8'd1,  8'h02, 1'b1, 1'b0, 0, "shl_81_1");
        do_op(3'd6, 8'h01, 8'd1,  8'h00, 1'b1, 1'b0, 0, "shr_01_1");
        do_op(3'd7, 8'd10, 8'd5,  8'd50, 1'b0, 1'b0, 0, "mul_10_5");
        do_op(3'd7, 8'd16, 8'd16, 8'h00, 1'b1, 1'b0, 0, "mul_16_16");

        // Backpressure with junk requests driven while DONE.
        do_op(3'd0, 8'd3, 8'd4, 8'd7, 1'b0, 1'b0, 3, "backpressure");

        // Reset three cycles into a MUL.
        op = 3'd7;
        a = 8'd10;
        b = 8'd5;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_cleared("mid_mul_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("after_reset_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("after_reset_no_out_valid", 32'(out_valid), 32'd0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 150; i++) begin
            ro = 3'($urandom);
            rx = pick_operand();
            ry = pick_operand();
            m = model(ro, int'(rx), int'(ry));
            do_op(ro, rx, ry, m[7:0], m[9], m[8], int'($urandom % 3), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range >= 4.
REQ-002 Derived constant SHW = clog2(WIDTH), the shift-amount width; it is not overridable.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 b  input  WIDTH  operand B, unsigned or two's complement.
REQ-009 op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 result  output  WIDTH  registered result.
REQ-013 zero  output  1  result == 0.
REQ-014 carry  output  1  carry/borrow/shift-out/multiply-overflow flag.
REQ-015 overflow  output  1  signed overflow flag.
REQ-016 negative  output  1  result[WIDTH-1].

Function
REQ-017 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-018 in_ready SHALL be 1 only in IDLE.
REQ-019 out_valid SHALL be 1 only in DONE.
REQ-020 A request is accepted on the edge where in_valid && in_ready; a, b and op are captured on that edge only.
REQ-021 Non-MUL ops: IDLE->DONE on the accept edge, with result and flags registered on that edge; out_valid is high in the next cycle.
REQ-022 MUL: IDLE->BUSY on the accept edge; one shift-add iteration per edge using a counter; BUSY->DONE after exactly WIDTH further edges, so out_valid is high WIDTH+1 cycles after the accept cycle.
REQ-023 MUL result SHALL be the low WIDTH bits of the unsigned product.
REQ-024 MUL carry SHALL be 1 iff the high WIDTH bits of the product are nonzero; MUL overflow SHALL be 0.
REQ-025 DONE->IDLE SHALL occur on the edge where out_ready = 1; a new request can be accepted no earlier than the following cycle.
REQ-026 While in DONE with out_ready = 0, result and all flags SHALL hold stable indefinitely.
REQ-027 in_valid, a, b and op SHALL be ignored in BUSY and DONE; out_ready SHALL be ignored in IDLE and BUSY.
REQ-028 ADD: result = (a+b) mod 2^WIDTH; carry = carry-out; overflow = operands have equal signs and result sign differs.
REQ-029 SUB: result = (a-b) mod 2^WIDTH; carry = borrow (1 iff a < b unsigned); overflow = operands have different signs and result sign differs from a.
REQ-030 AND/OR/XOR: bitwise result; carry = 0; overflow = 0.
REQ-031 SHL/SHR: shift amount = b[SHW-1:0]; vacated bits filled with 0; carry = last bit shifted out, or 0 if the amount is 0; overflow = 0.
REQ-032 zero and negative SHALL be derived from the registered result for every op.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, in_ready = 1, out_valid = 0, result = 0, all flags = 0, and MUL counter/accumulator = 0, independent of clk.
REQ-034 Reset during BUSY or DONE SHALL discard the operation in flight; no out_valid follows it.
REQ-035 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification (WIDTH = 8)
REQ-036 a=10, b=5, ops 000..110, each issued with out_ready=1 -> results 15, 5, 0, 15, 15, 0x40, 0x00; every out_valid one cycle after its accept.
REQ-037 ADD 0x7F+0x01 -> 0x80, overflow=1, negative=1, carry=0; ADD 0xFF+0x01 -> 0x00, zero=1, carry=1, overflow=0.
REQ-038 SUB 5-10 -> 0xFB, carry=1, negative=1, overflow=0; SHL 0x81 by 1 -> 0x02, carry=1; SHR 0x01 by 1 -> 0x00, carry=1, zero=1.
REQ-039 MUL 10*5 -> 50, out_valid exactly 9 cycles after accept, in_ready=0 throughout; MUL 16*16 -> 0x00, carry=1, zero=1.
REQ-040 Backpressure: hold out_ready=0 for 3 cycles in DONE while driving new in_valid/a/b -> result and flags unchanged, in_ready=0, no new accept.
REQ-041 Assert rst_n low 3 cycles into a MUL -> all outputs cleared asynchronously; after release in_ready=1 and no stale out_valid appears.
